// File: rtl/uart_pkg.sv
// Shared types for the configurable UART transmitter.
// Holds the parity/state enums and the frame-length helper.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_EVEN,
        PARITY_ODD
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    function automatic int frame_bits(
        input int      data_bits,
        input parity_e parity,
        input int      stop_bits
    );
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with read-first combinational output.
// A push into a full FIFO is dropped even if a pop happens that cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with 5-8 data bits, optional parity, 1-2 stop bits
// and an input FIFO so queued characters go out with no idle gap.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int      NUM_CLKS_PER_BIT = 16,
    parameter int      DATA_BITS        = 8,
    parameter parity_e PARITY           = PARITY_NONE,
    parameter int      STOP_BITS        = 1,
    parameter int      FIFO_DEPTH       = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [DATA_BITS-1:0]          tx_din,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(NUM_CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    if (NUM_CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("NUM_CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
        $error("DATA_BITS must be in 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_e            state;
    logic [CW-1:0]        clk_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 par_bit;
    logic                 full;
    logic                 empty;
    logic                 tick;
    logic                 last_stop;
    logic                 pop;

    assign tick      = clk_cnt == CW'(NUM_CLKS_PER_BIT - 1);
    assign last_stop = bit_idx == BW'(STOP_BITS - 1);
    // Pop either from idle or on the final stop cycle for a zero-gap restart.
    assign pop       = !empty && (state == IDLE || (state == STOP && tick && last_stop));
    assign tx_ready  = !full;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (tx_valid),
        .pop   (pop),
        .din   (tx_din),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_busy <= state != IDLE;
            if (state != IDLE) begin
                clk_cnt <= tick ? '0 : clk_cnt + 1'b1;
            end
            if (pop) begin
                shreg   <= fifo_dout;
                par_bit <= (^fifo_dout) ^ (PARITY == PARITY_ODD);
            end
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!empty) begin
                        state <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (tick) begin
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    tx <= shreg[0];
                    if (tick) begin
                        shreg <= shreg >> 1;
                        if (bit_idx == BW'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= (PARITY == PARITY_NONE) ? STOP : uart_pkg::PARITY;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    tx <= par_bit;
                    if (tick) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (tick) begin
                        if (last_stop) begin
                            tx_done <= 1'b1;
                            bit_idx <= '0;
                            state   <= empty ? IDLE : START;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
